// File: rtl/llc_mem_responder_pkg.sv
// Shared types for the LLC memory responder: line and address widths, request/response
// layouts, FSM state encoding and a saturating counter helper.
package llc_mem_responder_pkg;

    localparam int LINE_ADDR_BITS = 28;
    localparam int BITS_PER_LINE  = 128;

    typedef logic [BITS_PER_LINE-1:0]  line_t;
    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;

    typedef struct packed {
        logic       hwrite;
        logic [2:0] hsize;
        logic [1:0] hprot;
        line_addr_t addr;
        line_t      line;
    } llc_mem_req_t;

    typedef struct packed {
        line_t line;
    } llc_mem_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RSP  = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/llc_mem_responder_if.sv
// LLC memory request/response bus; master is the cache side, slave is the responder.
interface llc_mem_responder_if;
    import llc_mem_responder_pkg::*;

    logic       llc_mem_req_valid;
    logic       llc_mem_req_ready;
    logic       llc_mem_req_hwrite;
    logic [2:0] llc_mem_req_hsize;
    logic [1:0] llc_mem_req_hprot;
    line_addr_t llc_mem_req_addr;
    line_t      llc_mem_req_line;
    logic       llc_mem_rsp_valid;
    logic       llc_mem_rsp_ready;
    line_t      llc_mem_rsp_line;

    modport master (
        output llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize, llc_mem_req_hprot,
        output llc_mem_req_addr, llc_mem_req_line, llc_mem_rsp_ready,
        input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line
    );

    modport slave (
        input  llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize, llc_mem_req_hprot,
        input  llc_mem_req_addr, llc_mem_req_line, llc_mem_rsp_ready,
        output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line
    );

endinterface

// File: rtl/llc_mem_responder_ram.sv
// 1R1W line RAM, 1-cycle read latency; same-cycle write to the read index forwards new data.
// No backpressure; contents are never reset.
module llc_mem_responder_ram
    import llc_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  line_t                 wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output line_t                 rdata
);

    line_t mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/llc_mem_responder.sv
// Single-outstanding LLC memory responder: reads return a line LATENCY+2 cycles after accept,
// writes commit silently; req_ready is low while busy and rsp_valid holds until rsp_ready.
module llc_mem_responder
    import llc_mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int LATENCY        = 4
) (
    input  logic               clk,
    input  logic               rst,
    llc_mem_responder_if.slave bus,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
);

    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    typedef logic [CNT_W-1:0] cnt_t;

    state_t       state_q, state_d;
    cnt_t         cnt_q, cnt_d;
    llc_mem_req_t req_q;
    logic         accept, ram_we, ram_re;
    logic [15:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    line_t        ram_rdata;
    logic [MEM_DEPTH_LOG2-1:0] ram_idx;
    logic         unused_req;

    // Every action is gated by rst so a pending write can never commit in the reset cycle.
    always_comb begin
        state_d               = state_q;
        cnt_d                 = cnt_q;
        accept                = 1'b0;
        ram_we                = 1'b0;
        ram_re                = 1'b0;
        bus.llc_mem_req_ready = 1'b0;
        bus.llc_mem_rsp_valid = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    bus.llc_mem_req_ready = 1'b1;
                    if (bus.llc_mem_req_valid) begin
                        accept  = 1'b1;
                        cnt_d   = cnt_t'(LATENCY);
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (req_q.hwrite) begin
                            ram_we  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ram_re  = 1'b1;
                            state_d = RSP;
                        end
                    end else begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
                RSP: begin
                    bus.llc_mem_rsp_valid = 1'b1;
                    if (bus.llc_mem_rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rd_cnt_d = (accept && !bus.llc_mem_req_hwrite) ? sat_inc16(rd_cnt_q) : rd_cnt_q;
    assign wr_cnt_d = ram_we ? sat_inc16(wr_cnt_q) : wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_q <= '{hwrite: bus.llc_mem_req_hwrite,
                       hsize:  bus.llc_mem_req_hsize,
                       hprot:  bus.llc_mem_req_hprot,
                       addr:   bus.llc_mem_req_addr,
                       line:   bus.llc_mem_req_line};
        end
    end

    // Upper address bits alias onto the RAM index; size and protection carry no meaning here.
    assign ram_idx    = req_q.addr[MEM_DEPTH_LOG2-1:0];
    assign unused_req = ^{req_q.hsize, req_q.hprot, req_q.addr[LINE_ADDR_BITS-1:MEM_DEPTH_LOG2]};

    llc_mem_responder_ram #(
        .DEPTH_LOG2(MEM_DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_idx),
        .wdata (req_q.line),
        .re    (ram_re),
        .raddr (ram_idx),
        .rdata (ram_rdata)
    );

    // RAM output stays put during RSP because no further read is issued until the handshake.
    assign bus.llc_mem_rsp_line = bus.llc_mem_rsp_valid ? ram_rdata : '0;
    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_llc_mem_responder.sv
// Scoreboard bench for llc_mem_responder: one instance with LATENCY=4, one with LATENCY=0.
module tb_llc_mem_responder;
    import llc_mem_responder_pkg::*;

    typedef struct {
        line_t line;
        int    cyc;
        int    dut;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    exp_t exp_q[$];
    bit   seen [2];

    llc_mem_responder_if i4 ();
    llc_mem_responder_if i0 ();
    logic [15:0] rd4, wr4, rd0, wr0;

    llc_mem_responder #(.MEM_DEPTH_LOG2(10), .LATENCY(4)) u4 (
        .clk(clk), .rst(rst), .bus(i4), .rd_count(rd4), .wr_count(wr4)
    );
    llc_mem_responder #(.MEM_DEPTH_LOG2(10), .LATENCY(0)) u0 (
        .clk(clk), .rst(rst), .bus(i0), .rd_count(rd0), .wr_count(wr0)
    );

    logic [1:0] m_vld, m_rdy;
    line_t      m_line [2];
    assign m_vld     = {i0.llc_mem_rsp_valid, i4.llc_mem_rsp_valid};
    assign m_rdy     = {i0.llc_mem_rsp_ready, i4.llc_mem_rsp_ready};
    assign m_line[0] = i4.llc_mem_rsp_line;
    assign m_line[1] = i0.llc_mem_rsp_line;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: first-valid cycle and line are compared against the head of the scoreboard.
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (!m_vld[j]) begin
                seen[j] = 1'b0;
            end else begin
                if (!seen[j]) begin
                    seen[j] = 1'b1;
                    chk("rsp_expected", 128'(exp_q.size() != 0 && exp_q[0].dut == j), 128'(1));
                    if (exp_q.size() != 0) chk("rsp_first_cycle", 128'(cyc), 128'(exp_q[0].cyc));
                end
                if (m_rdy[j] && exp_q.size() != 0) begin
                    chk("rsp_line", m_line[j], exp_q[0].line);
                    void'(exp_q.pop_front());
                    seen[j] = 1'b0;
                end
            end
        end
    end

    task automatic send(input int d, input logic wr, input line_addr_t a, input line_t l,
                        output int acc);
        acc = -1;
        @(posedge clk); #1;
        if (d == 0) begin
            i4.llc_mem_req_valid = 1'b1; i4.llc_mem_req_hwrite = wr;
            i4.llc_mem_req_addr  = a;    i4.llc_mem_req_line   = l;
        end else begin
            i0.llc_mem_req_valid = 1'b1; i0.llc_mem_req_hwrite = wr;
            i0.llc_mem_req_addr  = a;    i0.llc_mem_req_line   = l;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((d == 0) ? i4.llc_mem_req_ready : i0.llc_mem_req_ready) begin
                acc = cyc;
                break;
            end
        end
        chk("req_accepted", 128'(acc >= 0), 128'(1));
        @(posedge clk); #1;
        i4.llc_mem_req_valid = 1'b0;
        i0.llc_mem_req_valid = 1'b0;
    endtask

    task automatic wr(input int d, input line_addr_t a, input line_t l);
        int acc;
        send(d, 1'b1, a, l, acc);
    endtask

    task automatic rd(input int d, input line_addr_t a, input line_t l);
        int acc;
        send(d, 1'b0, a, '0, acc);
        exp_q.push_back('{line: l, cyc: acc + 2 + ((d == 0) ? 4 : 0), dut: d});
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain", 128'(exp_q.size()), 128'(0));
    endtask

    localparam line_t L_A5 = {16{8'hA5}};
    localparam line_t L_5A = {16{8'h5A}};
    localparam line_t L_11 = {16{8'h11}};
    localparam line_t L_22 = {16{8'h22}};
    localparam line_t L_33 = {16{8'h33}};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    acc;
        bit    stable;
        line_t held;
        i4.llc_mem_req_valid = 1'b0; i4.llc_mem_req_hwrite = 1'b0;
        i4.llc_mem_req_hsize = 3'b100; i4.llc_mem_req_hprot = 2'b11;
        i4.llc_mem_req_addr  = '0;   i4.llc_mem_req_line   = '0;
        i4.llc_mem_rsp_ready = 1'b1;
        i0.llc_mem_req_valid = 1'b0; i0.llc_mem_req_hwrite = 1'b0;
        i0.llc_mem_req_hsize = 3'b010; i0.llc_mem_req_hprot = 2'b01;
        i0.llc_mem_req_addr  = '0;   i0.llc_mem_req_line   = '0;
        i0.llc_mem_rsp_ready = 1'b1;

        // Reset: ready low while rst is held, idle outputs right after.
        repeat (3) @(negedge clk);
        chk("rst_req_ready4", 128'(i4.llc_mem_req_ready), 128'(0));
        chk("rst_req_ready0", 128'(i0.llc_mem_req_ready), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 128'(i4.llc_mem_req_ready), 128'(1));
        chk("post_rst_rsp_valid", 128'(i4.llc_mem_rsp_valid), 128'(0));
        chk("post_rst_rsp_line", i4.llc_mem_rsp_line, 128'(0));
        chk("post_rst_rd_count", 128'(rd4), 128'(0));
        chk("post_rst_wr_count", 128'(wr4), 128'(0));

        // Write then read back, LATENCY=4.
        wr(0, 28'h0000010, L_A5);
        rd(0, 28'h0000010, L_A5);
        drain();
        chk("t1_wr_count", 128'(wr4), 128'(1));
        chk("t1_rd_count", 128'(rd4), 128'(1));

        // LATENCY=0: rsp in N+2, req_ready low in N+1 and N+2.
        wr(1, 28'h0000005, L_33);
        rd(1, 28'h0000005, L_33);
        @(negedge clk); chk("lat0_ready_n1", 128'(i0.llc_mem_req_ready), 128'(0));
        @(negedge clk); chk("lat0_ready_n2", 128'(i0.llc_mem_req_ready), 128'(0));
        @(negedge clk); chk("lat0_ready_n3", 128'(i0.llc_mem_req_ready), 128'(1));
        drain();
        chk("lat0_wr_count", 128'(wr0), 128'(1));
        chk("lat0_rd_count", 128'(rd0), 128'(1));

        // Backpressure: rsp_ready low for 10+ cycles.
        i4.llc_mem_rsp_ready = 1'b0;
        rd(0, 28'h0000010, L_A5);
        for (int k = 0; k < 20 && !i4.llc_mem_rsp_valid; k++) @(negedge clk);
        held   = i4.llc_mem_rsp_line;
        stable = i4.llc_mem_rsp_valid;
        repeat (10) begin
            @(negedge clk);
            if (!i4.llc_mem_rsp_valid || i4.llc_mem_rsp_line !== held || i4.llc_mem_req_ready)
                stable = 1'b0;
        end
        chk("hold_stable", 128'(stable), 128'(1));
        @(posedge clk); #1 i4.llc_mem_rsp_ready = 1'b1;
        @(negedge clk); chk("hold_ready_at_hs", 128'(i4.llc_mem_req_ready), 128'(0));
        @(negedge clk); chk("hold_ready_after_hs", 128'(i4.llc_mem_req_ready), 128'(1));
        drain();

        // Address aliasing modulo 1024 lines.
        wr(0, 28'h0000400, L_5A);
        rd(0, 28'h0000000, L_5A);
        drain();

        // Reset during WAIT of a write: old line survives, counters clear.
        wr(0, 28'h0000020, L_11);
        send(0, 1'b1, 28'h0000020, L_22, acc);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", 128'(i4.llc_mem_req_ready), 128'(0));
        chk("midrst_rsp_valid", 128'(i4.llc_mem_rsp_valid), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_rd_count", 128'(rd4), 128'(0));
        chk("midrst_wr_count", 128'(wr4), 128'(0));
        rd(0, 28'h0000020, L_11);
        drain();
        chk("midrst_wr_after", 128'(wr4), 128'(0));
        chk("midrst_rd_after", 128'(rd4), 128'(1));

        // Saturation of rd_count.
        @(negedge clk);
        force u4.rd_cnt_q = 16'hFFFD;
        @(negedge clk);
        release u4.rd_cnt_q;
        rd(0, 28'h0000010, L_A5);
        chk("sat_rd_fffe", 128'(rd4), 128'(16'hFFFE));
        rd(0, 28'h0000010, L_A5);
        rd(0, 28'h0000010, L_A5);
        drain();
        chk("sat_rd_ffff", 128'(rd4), 128'(16'hFFFF));
        chk("sat_wr_untouched", 128'(wr4), 128'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
